mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-wide data memory.
- Converts the EX/MEM byte address and access size into word-addressed memory commands.
- Performs byte/halfword extraction with sign or zero extension on loads.
- Performs a two-cycle read-modify-write for byte/halfword stores, stalling the pipeline for one cycle. Flags misaligned accesses.

Parameters:
- NB_DATA, 32, data word width.
- NB_ADDR, 7, data memory word-address width (128 words).
- NB_OP, 3, access-size/sign opcode width.

Ports:
- clock_i  in  1  system clock; all state updates on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  global run enable (debug step); low freezes all state.
- valid_i  in  1  request present from EX/MEM register.
- is_load_i  in  1  request is a load.
- is_store_i  in  1  request is a store; is_load_i and is_store_i both high is treated as no request.
- mem_op_i  in  NB_OP  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use size bits [1:0] only).
- addr_i  in  NB_ADDR+2  byte address (ALU result bits [8:0]).
- wdata_i  in  NB_DATA  store data (rt), right-justified.
- mem_enable_o  out  1  drives data memory enable.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  NB_ADDR  word address.
- mem_wdata_o  out  NB_DATA  full word written.
- mem_rdata_i  in  NB_DATA  memory read data; valid by next posedge (memory captures on negedge).
- load_data_o  out  NB_DATA  extended load result, registered.
- load_valid_o  out  1  one-cycle pulse, load_data_o valid.
- stall_o  out  1  combinational pipeline stall request.
- misaligned_o  out  1  one-cycle registered error pulse.

Behaviour:
- Reset (async): state IDLE; load_data_o=0; load_valid_o=0; misaligned_o=0; merge register=0. Memory strobes are combinational and therefore low in reset.
- Byte ordering is little-endian within a word: byte k = bits [8k+7:8k], with k = addr_i[1:0].
- Alignment: halfword requires addr_i[0]=0; word requires addr_i[1:0]=00.
- Misaligned request: no memory strobe; misaligned_o pulses at the next posedge; load_valid_o stays 0.
- States: IDLE, MERGE.
- IDLE, aligned load:
  - mem_enable_o=1, mem_read_o=1, mem_addr_o=addr_i[8:2].
  - At posedge: load_data_o = the selected byte/half/word, sign-extended (LB/LH) or zero-extended (LBU/LHU); load_valid_o=1.
  - Latency 1 cycle; no stall.
- IDLE, word store: mem_enable_o=1, mem_write_o=1, mem_wdata_o=wdata_i in the same cycle; no stall.
- IDLE, aligned byte/half store:
  - stall_o=1; mem_read_o=1 at the word address.
  - At posedge: latch the read word, address, offset, size and wdata into the merge register, then go to MERGE.
- MERGE:
  - stall_o=0; valid_i is ignored (the upstream request is still presented and is the same request).
  - mem_write_o=1; mem_wdata_o = latched word with the target byte/half replaced by wdata[7:0] or wdata[15:0].
  - Next state is IDLE unconditionally.
- No request (valid_i=0): all strobes low, outputs otherwise idle, load_valid_o=0 next cycle.
- enable_i=0: state and registers hold; mem_enable_o, mem_read_o, mem_write_o and stall_o are low; pulses do not re-fire.
- reset_i asserted during MERGE: returns to IDLE immediately and no write is issued. The partial store is lost by design.
- load_valid_o and misaligned_o are single-cycle pulses; they are never both high.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_OP_LB/LH/LW/LBU/LHU encodings and SIZE_BYTE/HALF/WORD constants.
  - State encoding ST_IDLE/ST_MERGE.
  - NB_DATA/NB_ADDR defaults.
- One natural combinational sub-module, load_extend: takes word, offset and op, and returns the extended data. It is reused by the forwarding path.
- Merge logic stays inline.

Test Plan:
- RAM[0]=0x80000005: LB addr 0 -> load_data_o=0x00000005, valid 1 cycle later; LB addr 3 -> 0xFFFFFF80; LBU addr 3 -> 0x00000080.
- RAM[0]=0x80000005: LH addr 2 -> 0xFFFF8000; LHU addr 2 -> 0x00008000; LW addr 0 -> 0x80000005.
- RAM[1]=0x00F00301, SB wdata=0x000000AB addr 5:
  - stall_o high exactly 1 cycle; mem_write_o in the MERGE cycle with data 0x00F0AB01.
  - A subsequent LW addr 4 returns 0x00F0AB01.
- Misalignment: LW addr 6 and SH addr 1 -> misaligned_o pulse; mem_read_o and mem_write_o never asserted; RAM unchanged.
- SH 0x1234 addr 4 issued, reset_i asserted during the MERGE cycle -> no mem_write_o; RAM[1] unchanged; all outputs 0; state IDLE.
- enable_i deasserted in the MERGE state for 3 cycles -> strobes low, state held; on re-enable the write of the merged word occurs once.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM-stage load/store unit.
// Opcode encodings, access sizes, FSM states and default widths.
package mem_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 7;
    localparam int NB_OP_DEF   = 3;

    localparam logic [2:0] MEM_OP_LB  = 3'b000;
    localparam logic [2:0] MEM_OP_LH  = 3'b001;
    localparam logic [2:0] MEM_OP_LW  = 3'b010;
    localparam logic [2:0] MEM_OP_LBU = 3'b100;
    localparam logic [2:0] MEM_OP_LHU = 3'b101;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    function automatic logic is_aligned(
        input logic [1:0] size,
        input logic [1:0] offset
    );
        logic ok;
        unique case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~offset[0];
            default:   ok = (offset == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects a byte/half/word from a memory word and sign/zero extends it.
// Shared between the load path and the forwarding path.
module load_extend
    import mem_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] word,
    input  logic [1:0]         offset,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] data
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic        sext;

    always_comb begin
        sel_b = word[{offset, 3'b000} +: 8];
        sel_h = word[{offset[1], 4'b0000} +: 16];
        // op[2] set means the unsigned variants LBU/LHU
        sext  = ~op[2];
        data  = word;
        unique case (op[1:0])
            SIZE_BYTE:
                data = {{(NB_DATA-8){sext & sel_b[7]}}, sel_b};
            SIZE_HALF:
                data = {{(NB_DATA-16){sext & sel_h[15]}}, sel_h};
            default:
                data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory.
// Sub-word stores use a two-cycle read-modify-write with a one-cycle stall.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               valid_i,
    input  logic               is_load_i,
    input  logic               is_store_i,
    input  logic [NB_OP-1:0]   mem_op_i,
    input  logic [NB_ADDR+1:0] addr_i,
    input  logic [NB_DATA-1:0] wdata_i,
    output logic               mem_enable_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0] mem_wdata_o,
    input  logic [NB_DATA-1:0] mem_rdata_i,
    output logic [NB_DATA-1:0] load_data_o,
    output logic               load_valid_o,
    output logic               stall_o,
    output logic               misaligned_o
);

    state_t             state;
    logic [NB_DATA-1:0] m_word;
    logic [NB_ADDR-1:0] m_addr;
    logic [1:0]         m_offset;
    logic [1:0]         m_size;
    logic [15:0]        m_wdata;

    logic               active;
    logic               req;
    logic               aligned;
    logic               idle_req;
    logic               do_load;
    logic               do_store_word;
    logic               do_rmw;
    logic               do_merge;
    logic               mis_req;
    logic [1:0]         size;
    logic [1:0]         offset;
    logic [NB_ADDR-1:0] word_addr;
    logic [NB_DATA-1:0] ext_data;
    logic [NB_DATA-1:0] merged;

    assign size      = mem_op_i[1:0];
    assign offset    = addr_i[1:0];
    assign word_addr = addr_i[NB_ADDR+1:2];

    // strobes must stay low while frozen or in reset
    assign active   = enable_i & ~reset_i;
    assign req      = valid_i & (is_load_i ^ is_store_i);
    assign aligned  = is_aligned(size, offset);
    assign idle_req = active & (state == ST_IDLE) & req;

    assign do_load       = idle_req & aligned & is_load_i;
    assign do_store_word = idle_req & aligned & is_store_i & size[1];
    assign do_rmw        = idle_req & aligned & is_store_i & ~size[1];
    assign mis_req       = idle_req & ~aligned;
    assign do_merge      = active & (state == ST_MERGE);

    always_comb begin
        merged = m_word;
        if (m_size == SIZE_BYTE)
            merged[{m_offset, 3'b000} +: 8] = m_wdata[7:0];
        else
            merged[{m_offset[1], 4'b0000} +: 16] = m_wdata;
    end

    assign mem_read_o   = do_load | do_rmw;
    assign mem_write_o  = do_store_word | do_merge;
    assign mem_enable_o = mem_read_o | mem_write_o;
    assign stall_o      = do_rmw;
    assign mem_addr_o   = (state == ST_MERGE) ? m_addr : word_addr;
    assign mem_wdata_o  = (state == ST_MERGE) ? merged : wdata_i;

    load_extend #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_load_extend (
        .word   (mem_rdata_i),
        .offset (offset),
        .op     (mem_op_i),
        .data   (ext_data)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= ST_IDLE;
            load_data_o  <= '0;
            load_valid_o <= 1'b0;
            misaligned_o <= 1'b0;
            m_word       <= '0;
            m_addr       <= '0;
            m_offset     <= '0;
            m_size       <= '0;
            m_wdata      <= '0;
        end else if (enable_i) begin
            load_valid_o <= do_load;
            misaligned_o <= mis_req;
            if (do_load)
                load_data_o <= ext_data;
            unique case (state)
                ST_IDLE: begin
                    if (do_rmw) begin
                        m_word   <= mem_rdata_i;
                        m_addr   <= word_addr;
                        m_offset <= offset;
                        m_size   <= size;
                        m_wdata  <= wdata_i[15:0];
                        state    <= ST_MERGE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end else begin
            load_valid_o <= 1'b0;
            misaligned_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, byte-level reference
// model checked every cycle, directed cases plus random traffic.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        valid_i;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  mem_op_i;
    logic [8:0]  addr_i;
    logic [31:0] wdata_i;
    logic        mem_enable_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [6:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        stall_o;
    logic        misaligned_o;

    mem_access_unit dut (
        .clock_i      (clock),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .valid_i      (valid_i),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_enable_o (mem_enable_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [128];
    logic [31:0] exp_ram [128];

    always @(negedge clock) begin
        if (mem_enable_o && mem_read_o)
            mem_rdata_i <= ram[mem_addr_o];
        if (mem_enable_o && mem_write_o)
            ram[mem_addr_o] <= mem_wdata_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extract(
        input logic [31:0] w, input int off, input logic [2:0] op);
        logic [31:0] r;
        if (op[1:0] == 2'd0) begin
            r = (w >> (8 * off)) & 32'hFF;
            if (!op[2] && r >= 32'h80) r = r | 32'hFFFFFF00;
        end else if (op[1:0] == 2'd1) begin
            r = (w >> (8 * off)) & 32'hFFFF;
            if (!op[2] && r >= 32'h8000) r = r | 32'hFFFF0000;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] replace(
        input logic [31:0] w, input int off,
        input int sz, input logic [31:0] wd);
        logic [31:0] m;
        m = (sz == 0) ? 32'hFF : 32'hFFFF;
        return (w & ~(m << (8 * off))) | ((wd & m) << (8 * off));
    endfunction

    // reference model state
    logic        mdl_pend = 1'b0;
    int          p_addr, p_off, p_size;
    logic [31:0] p_wd;
    logic [31:0] e_ld = '0;
    logic        e_lv = 1'b0;
    logic        e_mis = 1'b0;
    logic [31:0] n_ld;
    logic        n_lv, n_mis;
    logic        x_rd, x_wr, x_st;
    logic [31:0] x_addr, x_wd;
    int          sz, off, wa;
    logic        ok;

    int          n_stall = 0;
    int          n_read = 0;
    int          n_write = 0;
    logic [31:0] last_wd = '0;

    always @(negedge clock) begin
        if (reset_i) begin
            e_ld = '0; e_lv = 1'b0; e_mis = 1'b0;
        end
        chk("load_data", load_data_o, e_ld);
        chk("load_valid", 32'(load_valid_o), 32'(e_lv));
        chk("misaligned", 32'(misaligned_o), 32'(e_mis));
        x_rd = 0; x_wr = 0; x_st = 0; x_addr = 0; x_wd = 0;
        n_ld = e_ld; n_lv = 0; n_mis = 0;
        if (!reset_i && enable_i) begin
            if (mdl_pend) begin
                x_wr = 1;
                x_addr = 32'(p_addr);
                x_wd = replace(exp_ram[p_addr], p_off, p_size, p_wd);
                exp_ram[p_addr] = x_wd;
                mdl_pend = 0;
            end else if (valid_i && (is_load_i != is_store_i)) begin
                sz = int'(mem_op_i[1:0]);
                off = int'(addr_i[1:0]);
                wa = int'(addr_i[8:2]);
                ok = (sz == 0) || (sz == 1 && off % 2 == 0)
                     || (sz >= 2 && off == 0);
                x_addr = 32'(wa);
                if (!ok) begin
                    n_mis = 1;
                end else if (is_load_i) begin
                    x_rd = 1; n_lv = 1;
                    n_ld = extract(exp_ram[wa], off, mem_op_i);
                end else if (sz >= 2) begin
                    x_wr = 1; x_wd = wdata_i;
                    exp_ram[wa] = wdata_i;
                end else begin
                    x_rd = 1; x_st = 1; mdl_pend = 1;
                    p_addr = wa; p_off = off;
                    p_size = sz; p_wd = wdata_i;
                end
            end
        end
        if (reset_i) begin
            mdl_pend = 0; n_ld = '0;
        end
        chk("stall", 32'(stall_o), 32'(x_st));
        chk("mem_read", 32'(mem_read_o), 32'(x_rd));
        chk("mem_write", 32'(mem_write_o), 32'(x_wr));
        chk("mem_enable", 32'(mem_enable_o), 32'(x_rd | x_wr));
        if (x_rd || x_wr) chk("mem_addr", 32'(mem_addr_o), x_addr);
        if (x_wr) chk("mem_wdata", mem_wdata_o, x_wd);
        if (stall_o) n_stall++;
        if (mem_read_o) n_read++;
        if (mem_write_o) begin
            n_write++; last_wd = mem_wdata_o;
        end
        e_ld = n_ld; e_lv = n_lv; e_mis = n_mis;
    end

    task automatic idle();
        valid_i = 0; is_load_i = 0; is_store_i = 0;
    endtask

    task automatic req(input logic ld, input logic st,
                       input logic [2:0] op, input logic [8:0] a,
                       input logic [31:0] wd);
        valid_i = 1; is_load_i = ld; is_store_i = st;
        mem_op_i = op; addr_i = a; wdata_i = wd;
        @(posedge clock); #1;
        if (mdl_pend) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic clr_cnt();
        n_stall = 0; n_read = 0; n_write = 0;
    endtask

    logic [2:0] op_tab [5];
    int k;

    initial begin
        op_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 128; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i == 0) v = 32'h80000005;
            if (i == 1) v = 32'h00F00301;
            ram[i] <= v;
            exp_ram[i] = v;
        end
        reset_i = 1; enable_i = 1; mem_op_i = 0;
        addr_i = 0; wdata_i = 0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_load_data", load_data_o, 32'h0);
        chk("rst_load_valid", 32'(load_valid_o), 32'h0);
        chk("rst_misaligned", 32'(misaligned_o), 32'h0);
        chk("rst_mem_enable", 32'(mem_enable_o), 32'h0);
        reset_i = 0;
        @(posedge clock); #1;

        req(1, 0, 3'b000, 9'd0, 0);
        chk("lb0_valid", 32'(load_valid_o), 32'h1);
        chk("lb0", load_data_o, 32'h00000005);
        req(1, 0, 3'b000, 9'd3, 0);
        chk("lb3", load_data_o, 32'hFFFFFF80);
        req(1, 0, 3'b100, 9'd3, 0);
        chk("lbu3", load_data_o, 32'h00000080);
        req(1, 0, 3'b001, 9'd2, 0);
        chk("lh2", load_data_o, 32'hFFFF8000);
        req(1, 0, 3'b101, 9'd2, 0);
        chk("lhu2", load_data_o, 32'h00008000);
        req(1, 0, 3'b010, 9'd0, 0);
        chk("lw0", load_data_o, 32'h80000005);
        idle();
        @(posedge clock); #1;
        chk("lw0_pulse_end", 32'(load_valid_o), 32'h0);

        clr_cnt();
        req(0, 1, 3'b000, 9'd5, 32'h000000AB);
        idle();
        chk("sb_stall_cycles", 32'(n_stall), 32'd1);
        chk("sb_writes", 32'(n_write), 32'd1);
        chk("sb_wdata", last_wd, 32'h00F0AB01);
        chk("sb_ram", ram[1], 32'h00F0AB01);
        req(1, 0, 3'b010, 9'd4, 0);
        chk("lw4", load_data_o, 32'h00F0AB01);

        clr_cnt();
        req(1, 0, 3'b010, 9'd6, 0);
        chk("lw6_mis", 32'(misaligned_o), 32'h1);
        chk("lw6_valid", 32'(load_valid_o), 32'h0);
        req(0, 1, 3'b001, 9'd1, 32'hFFFF);
        chk("sh1_mis", 32'(misaligned_o), 32'h1);
        idle();
        @(posedge clock); #1;
        chk("mis_reads", 32'(n_read), 32'd0);
        chk("mis_writes", 32'(n_write), 32'd0);
        chk("mis_ram1", ram[1], 32'h00F0AB01);
        chk("mis_ram0", ram[0], 32'h80000005);

        clr_cnt();
        valid_i = 1; is_load_i = 0; is_store_i = 1;
        mem_op_i = 3'b001; addr_i = 9'd4; wdata_i = 32'h1234;
        @(posedge clock); #1;
        reset_i = 1;
        idle();
        #1;
        chk("rstm_write", 32'(mem_write_o), 32'h0);
        chk("rstm_stall", 32'(stall_o), 32'h0);
        chk("rstm_load_data", load_data_o, 32'h0);
        @(posedge clock); #1;
        reset_i = 0;
        @(posedge clock); #1;
        chk("rstm_writes", 32'(n_write), 32'd0);
        chk("rstm_ram1", ram[1], 32'h00F0AB01);

        clr_cnt();
        valid_i = 1; is_load_i = 0; is_store_i = 1;
        mem_op_i = 3'b000; addr_i = 9'd6; wdata_i = 32'h77;
        @(posedge clock); #1;
        enable_i = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("en_hold_writes", 32'(n_write), 32'd0);
        enable_i = 1;
        @(posedge clock); #1;
        idle();
        @(posedge clock); #1;
        chk("en_writes", 32'(n_write), 32'd1);
        chk("en_ram1", ram[1], 32'h0077AB01);

        for (int c = 0; c < 4000; c++) begin
            reset_i = ($urandom_range(0, 149) == 0);
            enable_i = ($urandom_range(0, 4) != 0);
            if (!mdl_pend) begin
                k = int'($urandom_range(0, 9));
                valid_i = (k != 0);
                is_load_i = (k < 5) || (k == 9);
                is_store_i = (k >= 5);
                mem_op_i = op_tab[$urandom_range(0, 4)];
                addr_i = 9'($urandom_range(0, 31));
                wdata_i = $urandom;
            end
            @(posedge clock); #1;
        end
        reset_i = 0; enable_i = 1;
        idle();
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++)
            chk("final_ram", ram[i], exp_ram[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
